// File: rtl/boot_image_loader.sv
// boot_image_loader
//   Receives a framed program image as a byte stream, assembles little-endian
//   32-bit words and writes them into user instruction memory. Firmware arms,
//   clears and monitors the loader through three bus registers.
//
//   Frame: HEADER, LEN_LO, LEN_HI (word count N), N*4 data bytes LSB first,
//          CSUM (8-bit modulo sum of all data bytes).
//
//   Ports
//     hb_clk, rst_sync      clock, asynchronous active-high reset
//     sys_share, sel        bus address/data fields and ren/wen strobes
//     rdata                 registered read data (updates the cycle after ren)
//     download_mode         external strap, must be 1 for a frame to run
//     rx_byte/valid/ready   byte stream; a byte moves when rx_valid && rx_ready
//     imem_we/addr/wdata    single-cycle IMEM word write
//     load_done             high while the loader sits in DONE
//     dbg_state             current FSM state
//
//   Registers: waddr 0 CTRL  bit0 arm, bit1 clear (clear wins)
//              raddr 0 STATUS {err[2:0], 0, done, busy, armed} in bits [6:0]
//              raddr 1 WORDS  word count, raddr 2 CSUM running sum

package boot_image_loader_pkg;
  typedef struct packed {
    logic [7:0]  raddr;
    logic [7:0]  waddr;
    logic [31:0] wdata;
  } sys_peripheral_t;

  typedef struct packed {
    logic ren;
    logic wen;
  } sel_t;
endpackage

module boot_image_loader
  import boot_image_loader_pkg::*;
#(
  parameter int         IMEM_AW = 12,
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         TIMEOUT = 1_000_000
) (
  input  logic                hb_clk,
  input  logic                rst_sync,
  input  sys_peripheral_t     sys_share,
  input  sel_t                sel,
  output logic [31:0]         rdata,
  input  logic                download_mode,
  input  logic [7:0]          rx_byte,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                imem_we,
  output logic [IMEM_AW-1:0]  imem_addr,
  output logic [31:0]         imem_wdata,
  output logic                load_done,
  output logic [2:0]          dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN0  = 3'd1;
  localparam logic [2:0] S_LEN1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam int          TW        = $clog2(TIMEOUT + 1);
  localparam logic [16:0] MAX_WORDS = 17'(2 ** IMEM_AW);

  logic [2:0]         state_q, state_d;
  logic               armed_q, armed_d;
  logic [2:0]         err_q, err_d;
  logic [IMEM_AW:0]   word_cnt_q, word_cnt_d;
  logic [7:0]         csum_q, csum_d;
  logic [7:0]         len_lo_q, len_lo_d;
  logic [15:0]        n_words_q, n_words_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [23:0]        word_buf_q, word_buf_d;
  logic               imem_we_q, imem_we_d;
  logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]        imem_wdata_q, imem_wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [TW-1:0]      tmo_q, tmo_d;

  logic        busy, accept, ctrl_wr, ctrl_set, ctrl_clr;
  logic [15:0] len_full;
  logic        unused_bits;

  assign unused_bits = ^sys_share.wdata[31:2];

  assign busy     = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                    (state_q == S_DATA) || (state_q == S_CSUM);
  assign rx_ready = (state_q != S_DONE) && (state_q != S_ERROR);
  assign accept   = rx_valid && rx_ready;
  assign ctrl_wr  = sel.wen && (sys_share.waddr == 8'd0);
  assign ctrl_set = ctrl_wr && sys_share.wdata[0];
  assign ctrl_clr = ctrl_wr && sys_share.wdata[1];
  assign len_full = {rx_byte, len_lo_q};

  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    err_d        = err_q;
    word_cnt_d   = word_cnt_q;
    csum_d       = csum_q;
    len_lo_d     = len_lo_q;
    n_words_d    = n_words_q;
    byte_idx_d   = byte_idx_q;
    word_buf_d   = word_buf_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    // Idle time between accepted bytes inside a frame.
    tmo_d        = (busy && !accept) ? tmo_q + 1'b1 : '0;

    if (ctrl_clr) begin
      // Clear beats everything, including a byte handshaked this cycle.
      state_d = S_IDLE;
      armed_d = 1'b0;
      err_d   = 3'd0;
    end else begin
      if (ctrl_set) armed_d = 1'b1;
      if (busy && !download_mode) begin
        state_d = S_ERROR;
        err_d   = 3'd4;
      end else if (accept) begin
        case (state_q)
          S_IDLE: begin
            if (rx_byte == HEADER && armed_q && download_mode) begin
              state_d    = S_LEN0;
              csum_d     = 8'd0;
              word_cnt_d = '0;
            end
          end
          S_LEN0: begin
            len_lo_d = rx_byte;
            state_d  = S_LEN1;
          end
          S_LEN1: begin
            n_words_d = len_full;
            if ({1'b0, len_full} > MAX_WORDS) begin
              state_d = S_ERROR;
              err_d   = 3'd2;
            end else if (len_full == 16'd0) begin
              state_d = S_CSUM;
            end else begin
              state_d    = S_DATA;
              byte_idx_d = 2'd0;
            end
          end
          S_DATA: begin
            csum_d     = csum_q + rx_byte;
            byte_idx_d = byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: word_buf_d[7:0]   = rx_byte;
              2'd1: word_buf_d[15:8]  = rx_byte;
              2'd2: word_buf_d[23:16] = rx_byte;
              default: begin
                imem_we_d    = 1'b1;
                imem_addr_d  = word_cnt_q[IMEM_AW-1:0];
                imem_wdata_d = {rx_byte, word_buf_q};
                word_cnt_d   = word_cnt_q + 1'b1;
                if (17'(word_cnt_q) + 17'd1 == {1'b0, n_words_q})
                  state_d = S_CSUM;
              end
            endcase
          end
          S_CSUM: begin
            if (rx_byte == csum_q) begin
              state_d = S_DONE;
              armed_d = 1'b0;  // a second image needs a fresh arm
            end else begin
              state_d = S_ERROR;
              err_d   = 3'd1;
            end
          end
          default: ;
        endcase
      end else if (busy && tmo_q == TW'(TIMEOUT - 1)) begin
        state_d = S_ERROR;
        err_d   = 3'd3;
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (sel.ren) begin
      case (sys_share.raddr)
        8'd0:    rdata_d = {25'b0, err_q, 1'b0, (state_q == S_DONE), busy, armed_q};
        8'd1:    rdata_d = 32'(word_cnt_q);
        8'd2:    rdata_d = {24'b0, csum_q};
        default: rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge hb_clk or posedge rst_sync) begin
    if (rst_sync) begin
      state_q      <= S_IDLE;
      armed_q      <= 1'b0;
      err_q        <= 3'd0;
      word_cnt_q   <= '0;
      csum_q       <= 8'd0;
      len_lo_q     <= 8'd0;
      n_words_q    <= 16'd0;
      byte_idx_q   <= 2'd0;
      word_buf_q   <= 24'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      rdata_q      <= 32'd0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      err_q        <= err_d;
      word_cnt_q   <= word_cnt_d;
      csum_q       <= csum_d;
      len_lo_q     <= len_lo_d;
      n_words_q    <= n_words_d;
      byte_idx_q   <= byte_idx_d;
      word_buf_q   <= word_buf_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      rdata_q      <= rdata_d;
      tmo_q        <= tmo_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign rdata      = rdata_q;
  assign load_done  = (state_q == S_DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_boot_image_loader.sv
// tb_boot_image_loader
//   Bench for boot_image_loader with a 16-word IMEM and a short timeout.
//   Expected IMEM writes are queued as bytes are driven and retired by a
//   write monitor; register contents are checked after each frame.

module tb_boot_image_loader;
  import boot_image_loader_pkg::*;

  localparam int         AW  = 4;
  localparam int         TMO = 64;
  localparam logic [7:0] HDR = 8'hA5;

  logic            hb_clk;
  logic            rst_sync;
  sys_peripheral_t sys_share;
  sel_t            sel;
  logic [31:0]     rdata;
  logic            download_mode;
  logic [7:0]      rx_byte;
  logic            rx_valid;
  logic            rx_ready;
  logic            imem_we;
  logic [AW-1:0]   imem_addr;
  logic [31:0]     imem_wdata;
  logic            load_done;
  logic [2:0]      dbg_state;

  boot_image_loader #(.IMEM_AW(AW), .HEADER(HDR), .TIMEOUT(TMO)) dut (
    .hb_clk(hb_clk), .rst_sync(rst_sync), .sys_share(sys_share), .sel(sel),
    .rdata(rdata), .download_mode(download_mode), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .load_done(load_done),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial hb_clk = 1'b0;
  always #5 hb_clk = ~hb_clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW+31:0] exp_q[$];
  logic [31:0] model_words = 0;
  logic [7:0]  model_csum  = 0;

  typedef struct {
    int          n;
    bit          arm;
    logic [7:0]  delta;
    logic [31:0] exp_status;
    logic        exp_ready;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: every IMEM write must match the head of the queue
  always @(negedge hb_clk) begin
    if (!rst_sync && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected", imem_addr, imem_wdata);
      end else begin
        check("imem_write", 64'({imem_addr, imem_wdata}), 64'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic bus_write(input logic [31:0] v);
    @(negedge hb_clk);
    sys_share.waddr = 8'd0;
    sys_share.wdata = v;
    sel.wen = 1'b1;
    @(posedge hb_clk); #1;
    sel.wen = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [31:0] exp);
    @(negedge hb_clk);
    sys_share.raddr = a;
    sel.ren = 1'b1;
    @(posedge hb_clk); #1;
    sel.ren = 1'b0;
    check(name, 64'(rdata), 64'(exp));
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    rx_byte  = b;
    rx_valid = 1'b1;
    k = 0;
    while (!rx_ready && k < 50) begin
      @(negedge hb_clk);
      k++;
    end
    if (!rx_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_ready_wait: got 0 expected 1 within 50 cycles");
    end else begin
      @(posedge hb_clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  // Sends one frame with random payload; csum byte is the true sum plus delta.
  task automatic run_frame(input int n, input bit arm, input logic [7:0] delta);
    logic [7:0]  sum;
    logic [31:0] w;
    logic [15:0] len;
    sum = 8'd0;
    len = 16'(n);
    send_byte(HDR);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    if (arm && n > 16) begin
      model_words = 0;
      model_csum  = 0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int b = 0; b < 4; b++) begin
        if (b == 3 && arm) exp_q.push_back({AW'(i), w});
        send_byte(w[8*b +: 8]);
        sum = sum + w[8*b +: 8];
      end
    end
    send_byte(sum + delta);
    if (arm) begin
      model_words = 32'(n);
      model_csum  = sum;
    end
  endtask

  task automatic send_list(input logic [7:0] bytes[], input int cnt);
    for (int i = 0; i < cnt; i++) send_byte(bytes[i]);
  endtask

  logic [7:0] frame1[12];
  logic [31:0] w_abort;

  initial begin
    vecs[0] = '{n: 2,  arm: 1'b0, delta: 8'h00, exp_status: 32'h00, exp_ready: 1'b1};
    vecs[1] = '{n: 1,  arm: 1'b1, delta: 8'h00, exp_status: 32'h04, exp_ready: 1'b0};
    vecs[2] = '{n: 3,  arm: 1'b1, delta: 8'h01, exp_status: 32'h11, exp_ready: 1'b0};
    vecs[3] = '{n: 16, arm: 1'b1, delta: 8'h00, exp_status: 32'h04, exp_ready: 1'b0};
    vecs[4] = '{n: 17, arm: 1'b1, delta: 8'h00, exp_status: 32'h21, exp_ready: 1'b0};
    vecs[5] = '{n: 0,  arm: 1'b1, delta: 8'h00, exp_status: 32'h04, exp_ready: 1'b0};
    vecs[6] = '{n: 5,  arm: 1'b1, delta: 8'h80, exp_status: 32'h11, exp_ready: 1'b0};
    frame1 = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};

    rst_sync = 1'b1;
    sys_share = '0;
    sel = '0;
    rx_valid = 1'b0;
    rx_byte = 8'd0;
    download_mode = 1'b1;
    repeat (3) @(negedge hb_clk);
    check("reset_rx_ready", 64'(rx_ready), 64'd1);
    check("reset_imem_we", 64'(imem_we), 64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    check("reset_load_done", 64'(load_done), 64'd0);
    rst_sync = 1'b0;
    read_check("reset_status", 8'd0, 32'h0);
    read_check("reset_words", 8'd1, 32'h0);

    // table-driven frames
    for (int v = 0; v < 7; v++) begin
      bus_write(32'h2);
      if (vecs[v].arm) bus_write(32'h1);
      run_frame(vecs[v].n, vecs[v].arm, vecs[v].delta);
      repeat (3) @(negedge hb_clk);
      check($sformatf("vec%0d_rx_ready", v), 64'(rx_ready), 64'(vecs[v].exp_ready));
      check($sformatf("vec%0d_load_done", v), 64'(load_done), 64'(vecs[v].exp_status[2]));
      check($sformatf("vec%0d_pending_writes", v), 64'(exp_q.size()), 64'd0);
      read_check($sformatf("vec%0d_status", v), 8'd0, vecs[v].exp_status);
      read_check($sformatf("vec%0d_words", v), 8'd1, model_words);
      read_check($sformatf("vec%0d_csum", v), 8'd2, {24'b0, model_csum});
    end
    read_check("unmapped_read", 8'd7, 32'h0);

    // known two-word image
    bus_write(32'h2);
    bus_write(32'h1);
    exp_q.push_back({AW'(0), 32'h0000_0013});
    exp_q.push_back({AW'(1), 32'h0010_0093});
    send_list(frame1, 12);
    repeat (2) @(negedge hb_clk);
    read_check("img_status", 8'd0, 32'h04);
    read_check("img_words", 8'd1, 32'd2);
    read_check("img_csum", 8'd2, 32'hB6);
    check("img_pending_writes", 64'(exp_q.size()), 64'd0);

    // same image, bad checksum, then clear
    bus_write(32'h2);
    bus_write(32'h1);
    exp_q.push_back({AW'(0), 32'h0000_0013});
    exp_q.push_back({AW'(1), 32'h0010_0093});
    frame1[11] = 8'hB7;
    send_list(frame1, 12);
    repeat (2) @(negedge hb_clk);
    read_check("badsum_status", 8'd0, 32'h11);
    check("badsum_rx_ready", 64'(rx_ready), 64'd0);
    bus_write(32'h2);
    read_check("cleared_status", 8'd0, 32'h0);
    check("cleared_rx_ready", 64'(rx_ready), 64'd1);

    // stall after two data bytes
    bus_write(32'h1);
    send_byte(HDR); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    repeat (TMO - 10) @(negedge hb_clk);
    read_check("stall_busy_status", 8'd0, 32'h03);
    repeat (TMO) @(negedge hb_clk);
    read_check("timeout_status", 8'd0, 32'h31);
    check("timeout_rx_ready", 64'(rx_ready), 64'd0);

    // download_mode drops right after a full word
    bus_write(32'h2);
    bus_write(32'h1);
    w_abort = $urandom;
    send_byte(HDR); send_byte(8'h02); send_byte(8'h00);
    exp_q.push_back({AW'(0), w_abort});
    for (int b = 0; b < 4; b++) send_byte(w_abort[8*b +: 8]);
    download_mode = 1'b0;
    repeat (2) @(negedge hb_clk);
    read_check("abort_status", 8'd0, 32'h41);
    check("abort_pending_writes", 64'(exp_q.size()), 64'd0);
    download_mode = 1'b1;

    // clear and a byte in the same cycle: clear wins
    bus_write(32'h2);
    bus_write(32'h1);
    send_byte(HDR);
    @(negedge hb_clk);
    rx_byte = 8'h01;
    rx_valid = 1'b1;
    sys_share.waddr = 8'd0;
    sys_share.wdata = 32'h3;
    sel.wen = 1'b1;
    @(posedge hb_clk); #1;
    rx_valid = 1'b0;
    sel.wen = 1'b0;
    read_check("clr_vs_byte_status", 8'd0, 32'h0);

    // reset in the middle of DATA
    bus_write(32'h1);
    send_byte(HDR); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    @(negedge hb_clk);
    rst_sync = 1'b1;
    #1;
    check("midrst_imem_we", 64'(imem_we), 64'd0);
    check("midrst_imem_addr", 64'(imem_addr), 64'd0);
    check("midrst_imem_wdata", 64'(imem_wdata), 64'd0);
    check("midrst_rdata", 64'(rdata), 64'd0);
    check("midrst_rx_ready", 64'(rx_ready), 64'd1);
    check("midrst_load_done", 64'(load_done), 64'd0);
    @(negedge hb_clk);
    rst_sync = 1'b0;
    read_check("midrst_status", 8'd0, 32'h0);
    read_check("midrst_words", 8'd1, 32'h0);
    read_check("midrst_csum", 8'd2, 32'h0);
    check("final_pending_writes", 64'(exp_q.size()), 64'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
